// File: rtl/rv32i_decode_stage.sv
// IF/ID stage of the RV32I core: decodes the major opcode into immediate format,
// class and write-enable, and holds results in a two-entry skid buffer.
module rv32i_decode_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imgsel,
  output logic [3:0]      out_cls,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic            out_reg_we,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      imgsel;
    logic [3:0]      cls;
    logic            regWe;
    logic            illegal;
  } entry_t;

  localparam entry_t NopEntry = '{
    inst:    XLEN'(32'h0000_0013),
    pc:      RESET_PC,
    imgsel:  3'b000,
    cls:     4'd1,
    regWe:   1'b0,
    illegal: 1'b0
  };

  entry_t dec;
  entry_t mainQ, mainD;
  entry_t skidQ, skidD;
  logic   mainValidQ, mainValidD;
  logic   skidValidQ, skidValidD;
  logic   inReadyQ, inReadyD;
  logic   writesRd;
  logic   inAcc;
  logic   mainLoad;

  // Decode the incoming word; anything outside the map (including inst[1:0] != 11) is illegal.
  always_comb begin
    dec         = '0;
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.imgsel  = 3'b111;
    dec.cls     = 4'd15;
    dec.illegal = 1'b1;
    writesRd    = 1'b0;
    case (in_inst[6:0])
      7'b0110011: begin dec.cls = 4'd0;  dec.imgsel = 3'b111; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0010011: begin dec.cls = 4'd1;  dec.imgsel = 3'b000; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0000011: begin dec.cls = 4'd2;  dec.imgsel = 3'b000; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0100011: begin dec.cls = 4'd3;  dec.imgsel = 3'b001; dec.illegal = 1'b0; end
      7'b1100011: begin dec.cls = 4'd4;  dec.imgsel = 3'b010; dec.illegal = 1'b0; end
      7'b1101111: begin dec.cls = 4'd5;  dec.imgsel = 3'b100; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b1100111: begin dec.cls = 4'd6;  dec.imgsel = 3'b000; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0110111: begin dec.cls = 4'd7;  dec.imgsel = 3'b011; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0010111: begin dec.cls = 4'd8;  dec.imgsel = 3'b011; dec.illegal = 1'b0; writesRd = 1'b1; end
      7'b0001111: begin dec.cls = 4'd9;  dec.imgsel = 3'b000; dec.illegal = 1'b0; end
      7'b1110011: begin dec.cls = 4'd10; dec.imgsel = 3'b000; dec.illegal = 1'b0; end
      default: ;
    endcase
    dec.regWe = writesRd && (in_inst[11:7] != 5'd0);
  end

  // Main drains/refills whenever empty or consumed; skid catches the word that arrives
  // while main is stalled, and always feeds main before any newer input.
  always_comb begin
    mainD      = mainQ;
    skidD      = skidQ;
    mainValidD = mainValidQ;
    skidValidD = skidValidQ;
    inAcc      = in_valid && inReadyQ;
    mainLoad   = !mainValidQ || out_ready;
    if (flush) begin
      mainValidD = 1'b0;
      skidValidD = 1'b0;
    end else if (mainLoad) begin
      if (skidValidQ) begin
        mainD      = skidQ;
        mainValidD = 1'b1;
        skidValidD = inAcc;
        if (inAcc) skidD = dec;
      end else if (inAcc) begin
        mainD      = dec;
        mainValidD = 1'b1;
      end else begin
        mainValidD = 1'b0;
      end
    end else if (inAcc) begin
      skidD      = dec;
      skidValidD = 1'b1;
    end
    inReadyD = !skidValidD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainQ      <= NopEntry;
      skidQ      <= NopEntry;
      mainValidQ <= 1'b0;
      skidValidQ <= 1'b0;
      inReadyQ   <= 1'b1;
    end else begin
      mainQ      <= mainD;
      skidQ      <= skidD;
      mainValidQ <= mainValidD;
      skidValidQ <= skidValidD;
      inReadyQ   <= inReadyD;
    end
  end

  assign in_ready    = inReadyQ;
  assign out_valid   = mainValidQ;
  assign out_inst    = mainQ.inst;
  assign out_pc      = mainQ.pc;
  assign out_imgsel  = mainQ.imgsel;
  assign out_cls     = mainQ.cls;
  assign out_rd      = mainQ.inst[11:7];
  assign out_rs1     = mainQ.inst[19:15];
  assign out_rs2     = mainQ.inst[24:20];
  assign out_funct3  = mainQ.inst[14:12];
  assign out_reg_we  = mainQ.regWe;
  assign out_illegal = mainQ.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for rv32i_decode_stage: decode table, streaming, backpressure,
// flush, illegal opcodes and mid-run reset, all against hand-computed values.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInst;
  logic [31:0] inPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInst;
  logic [31:0] outPc;
  logic [2:0]  outImgsel;
  logic [3:0]  outCls;
  logic [4:0]  outRd;
  logic [4:0]  outRs1;
  logic [4:0]  outRs2;
  logic [2:0]  outFunct3;
  logic        outRegWe;
  logic        outIllegal;

  int testsRun    = 0;
  int testsFailed = 0;

  rv32i_decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_inst(inInst), .in_pc(inPc),
    .out_valid(outValid), .out_ready(outReady), .out_inst(outInst), .out_pc(outPc),
    .out_imgsel(outImgsel), .out_cls(outCls), .out_rd(outRd), .out_rs1(outRs1),
    .out_rs2(outRs2), .out_funct3(outFunct3), .out_reg_we(outRegWe),
    .out_illegal(outIllegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic [31:0] pc, input logic ordy,
                               input logic fl);
    inValid  = v;
    inInst   = inst;
    inPc     = pc;
    outReady = ordy;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkDecoded(input string tag, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [2:0] imgsel,
                              input logic [3:0] cls, input logic [4:0] rd,
                              input logic we, input logic ill);
    checkOutput({tag, ".valid"},   32'(outValid),   32'd1);
    checkOutput({tag, ".inst"},    outInst,         inst);
    checkOutput({tag, ".pc"},      outPc,           pc);
    checkOutput({tag, ".imgsel"},  32'(outImgsel),  32'(imgsel));
    checkOutput({tag, ".cls"},     32'(outCls),     32'(cls));
    checkOutput({tag, ".rd"},      32'(outRd),      32'(rd));
    checkOutput({tag, ".we"},      32'(outRegWe),   32'(we));
    checkOutput({tag, ".illegal"}, 32'(outIllegal), 32'(ill));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst.valid",  32'(outValid),  32'd0);
    checkOutput("rst.ready",  32'(inReady),   32'd1);
    checkOutput("rst.inst",   outInst,        32'h0000_0013);
    checkOutput("rst.pc",     outPc,          32'h0);
    checkOutput("rst.imgsel", 32'(outImgsel), 32'd0);
    checkOutput("rst.cls",    32'(outCls),    32'd1);
    checkOutput("rst.we",     32'(outRegWe),  32'd0);

    // addi x1,x0,5
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    tick();
    checkDecoded("addi", 32'h0050_0093, 32'h100, 3'b000, 4'd1, 5'd1, 1'b1, 1'b0);
    checkOutput("addi.rs1", 32'(outRs1), 32'd0);

    // back-to-back stream at full rate
    applyStimulus(1'b1, 32'h0011_2023, 32'h104, 1'b1, 1'b0);
    tick();
    checkDecoded("sw", 32'h0011_2023, 32'h104, 3'b001, 4'd3, 5'd0, 1'b0, 1'b0);
    checkOutput("sw.rs1",    32'(outRs1),    32'd2);
    checkOutput("sw.rs2",    32'(outRs2),    32'd1);
    checkOutput("sw.funct3", 32'(outFunct3), 32'd2);
    checkOutput("sw.ready",  32'(inReady),   32'd1);
    applyStimulus(1'b1, 32'hFE00_0EE3, 32'h108, 1'b1, 1'b0);
    tick();
    checkDecoded("beq", 32'hFE00_0EE3, 32'h108, 3'b010, 4'd4, 5'd29, 1'b0, 1'b0);
    checkOutput("beq.ready", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 32'h1234_50B7, 32'h10C, 1'b1, 1'b0);
    tick();
    checkDecoded("lui", 32'h1234_50B7, 32'h10C, 3'b011, 4'd7, 5'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0080_00EF, 32'h110, 1'b1, 1'b0);
    tick();
    checkDecoded("jal", 32'h0080_00EF, 32'h110, 3'b100, 4'd5, 5'd1, 1'b1, 1'b0);
    checkOutput("jal.ready", 32'(inReady), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain.valid", 32'(outValid), 32'd0);

    // backpressure: A in main, B in skid, C stalls
    applyStimulus(1'b1, 32'h00A0_0113, 32'h200, 1'b0, 1'b0);
    tick();
    checkDecoded("bpA", 32'h00A0_0113, 32'h200, 3'b000, 4'd1, 5'd2, 1'b1, 1'b0);
    checkOutput("bpA.ready", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 32'h00B0_0193, 32'h204, 1'b0, 1'b0);
    tick();
    checkOutput("bpB.hold",  outInst,        32'h00A0_0113);
    checkOutput("bpB.ready", 32'(inReady),   32'd0);
    applyStimulus(1'b1, 32'h00C0_0213, 32'h208, 1'b0, 1'b0);
    tick();
    checkOutput("bpC.hold",  outInst,        32'h00A0_0113);
    checkOutput("bpC.ready", 32'(inReady),   32'd0);
    applyStimulus(1'b1, 32'h00C0_0213, 32'h208, 1'b1, 1'b0);
    tick();
    checkDecoded("bpOutB", 32'h00B0_0193, 32'h204, 3'b000, 4'd1, 5'd3, 1'b1, 1'b0);
    checkOutput("bpOutB.ready", 32'(inReady), 32'd1);
    tick();
    checkDecoded("bpOutC", 32'h00C0_0213, 32'h208, 3'b000, 4'd1, 5'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("bpEnd.valid", 32'(outValid), 32'd0);

    // flush with main and skid full, then flush discarding an accepted input
    applyStimulus(1'b1, 32'h0010_0293, 32'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0020_0313, 32'h304, 1'b0, 1'b0);
    tick();
    checkOutput("fl.full", 32'(inReady), 32'd0);
    applyStimulus(1'b1, 32'h0030_0393, 32'h308, 1'b0, 1'b1);
    tick();
    checkOutput("fl.valid", 32'(outValid), 32'd0);
    checkOutput("fl.ready", 32'(inReady),  32'd1);
    applyStimulus(1'b1, 32'h0040_0413, 32'h30C, 1'b1, 1'b1);
    tick();
    checkOutput("fl2.valid", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("fl3.valid", 32'(outValid), 32'd0);
    checkOutput("fl3.ready", 32'(inReady),  32'd1);

    // illegal opcodes, then normal operation resumes
    applyStimulus(1'b1, 32'h0000_007F, 32'h400, 1'b1, 1'b0);
    tick();
    checkDecoded("ill7F", 32'h0000_007F, 32'h400, 3'b111, 4'd15, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0000, 32'h404, 1'b1, 1'b0);
    tick();
    checkDecoded("ill00", 32'h0000_0000, 32'h404, 3'b111, 4'd15, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0013, 32'h408, 1'b1, 1'b0);
    tick();
    checkDecoded("nopX0", 32'h0000_0013, 32'h408, 3'b000, 4'd1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0093, 32'h40C, 1'b1, 1'b0);
    tick();
    checkDecoded("resume", 32'h0050_0093, 32'h40C, 3'b000, 4'd1, 5'd1, 1'b1, 1'b0);

    // reset while holding an instruction
    applyStimulus(1'b1, 32'h0060_0493, 32'h500, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checkOutput("mrst.valid", 32'(outValid), 32'd0);
    checkOutput("mrst.inst",  outInst,       32'h0000_0013);
    checkOutput("mrst.pc",    outPc,         32'h0);
    checkOutput("mrst.ready", 32'(inReady),  32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
